// File: rtl/ffs_lock_scheduler.sv
// ---------------------------------------------------------------------------
// ffs_lock_scheduler
//
// Shares one multi-cycle resource among CLIENTS requesters using round-robin
// arbitration. The highest index wins first. After an owner releases, priority
// rotates down to the indices below the previous owner. The winner keeps an
// exclusive grant until one of three events occurs:
//   - it pulses done,
//   - it drops its request, or
//   - the MAX_HOLD limit expires.
// Between two owners there is always at least one cycle with gnt all-zero, so
// the shared datapath has time to turn around.
//
// Ports
//   clk      in   1        clock
//   rst_n    in   1        asynchronous active-low reset
//   req      in   CLIENTS  level request per client
//   done     in   CLIENTS  release pulse; only the owner's bit is honoured
//   gnt      out  CLIENTS  one-hot ownership (registered), zero when idle
//   gnt_vld  out  1        |gnt (registered)
//   gnt_idx  out  IDX_W    owner index, meaningful only while gnt_vld
//   preempt  out  1        one-cycle pulse when ownership ended by MAX_HOLD
//   busy     out  1        scheduler is in the OWN state (== gnt_vld)
// ---------------------------------------------------------------------------
module ffs_lock_scheduler #(
    parameter int  CLIENTS  = 16,
    parameter int  MAX_HOLD = 8,
    localparam int IDX_W    = $clog2(CLIENTS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CLIENTS-1:0] req,
    input  logic [CLIENTS-1:0] done,
    output logic [CLIENTS-1:0] gnt,
    output logic               gnt_vld,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               preempt,
    output logic               busy
);

    // Hold counter is wide enough to reach MAX_HOLD. It is 1 bit when the
    // limit is disabled (MAX_HOLD = 0).
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = {HOLD_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CLIENTS-1:0]  gnt_r;
    logic [CLIENTS-1:0]  gnt_s;
    logic [IDX_W-1:0]    gnt_idx_r;
    logic [IDX_W-1:0]    gnt_idx_s;
    logic                gnt_vld_r;
    logic                busy_r;
    logic                preempt_r;
    logic                preempt_s;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_s;
    logic [CLIENTS-1:0]  mask_r;
    logic [CLIENTS-1:0]  mask_s;
    logic [CLIENTS-1:0]  req_m_s;
    logic [IDX_W-1:0]    winner_s;
    logic [CLIENTS-1:0]  release_mask_s;
    logic                rel_done_s;
    logic                rel_drop_s;
    logic                rel_expire_s;
    logic                rel_any_s;

    // Find-first-set from the top: returns the highest set bit index of v.
    // The result is 0 when v is empty.
    function automatic logic [IDX_W-1:0] highest_set(input logic [CLIENTS-1:0] v);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int i = 0; i < CLIENTS; i++) begin
            r = v[i] ? IDX_W'(i) : r;
        end
        return r;
    endfunction

    // One-hot decode of a client index.
    function automatic logic [CLIENTS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [CLIENTS-1:0] r;
        r = {CLIENTS{1'b0}};
        for (int i = 0; i < CLIENTS; i++) begin
            r[i] = (IDX_W'(i) == idx);
        end
        return r;
    endfunction

    // Masked requests take priority. Fall back to the full vector when no
    // client below the previous owner is requesting.
    always_comb begin
        req_m_s  = req & mask_r;
        winner_s = (|req_m_s) ? highest_set(req_m_s) : highest_set(req);
    end

    // Rotation mask after a release: only indices strictly below the owner.
    always_comb begin
        release_mask_s = {CLIENTS{1'b0}};
        for (int i = 0; i < CLIENTS; i++) begin
            release_mask_s[i] = (IDX_W'(i) < gnt_idx_r);
        end
    end

    // Release conditions, evaluated against the current owner only.
    always_comb begin
        rel_done_s   = done[gnt_idx_r];
        rel_drop_s   = ~req[gnt_idx_r];
        rel_expire_s = (MAX_HOLD != 0) && (hold_cnt_r == HOLD_LIMIT);
        rel_any_s    = rel_done_s | rel_drop_s | rel_expire_s;
    end

    // Next-state and next-output logic of the IDLE/OWN ownership FSM.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        gnt_idx_s  = gnt_idx_r;
        hold_cnt_s = hold_cnt_r;
        mask_s     = mask_r;
        preempt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    gnt_s      = onehot(winner_s);
                    gnt_idx_s  = winner_s;
                    hold_cnt_s = HOLD_ONE;
                    state_s    = ST_OWN;
                end else begin
                    gnt_s      = {CLIENTS{1'b0}};
                end
            end
            ST_OWN: begin
                if (rel_any_s) begin
                    gnt_s     = {CLIENTS{1'b0}};
                    mask_s    = release_mask_s;
                    state_s   = ST_IDLE;
                    // Preempt flags only a pure timeout, not a voluntary release.
                    preempt_s = rel_expire_s & ~rel_done_s & ~rel_drop_s;
                end else begin
                    // Saturate so an unlimited hold never wraps.
                    hold_cnt_s = (hold_cnt_r == HOLD_SAT) ? hold_cnt_r
                                                          : (hold_cnt_r + HOLD_ONE);
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = {CLIENTS{1'b0}};
            end
        endcase
    end

    // State and registered outputs. gnt_vld and busy are derived from the
    // next-state values so they stay in lockstep with gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gnt_r      <= {CLIENTS{1'b0}};
            gnt_idx_r  <= {IDX_W{1'b0}};
            gnt_vld_r  <= 1'b0;
            busy_r     <= 1'b0;
            preempt_r  <= 1'b0;
            hold_cnt_r <= {HOLD_W{1'b0}};
            mask_r     <= {CLIENTS{1'b0}};
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            gnt_idx_r  <= gnt_idx_s;
            gnt_vld_r  <= |gnt_s;
            busy_r     <= (state_s == ST_OWN);
            preempt_r  <= preempt_s;
            hold_cnt_r <= hold_cnt_s;
            mask_r     <= mask_s;
        end
    end

    assign gnt     = gnt_r;
    assign gnt_vld = gnt_vld_r;
    assign gnt_idx = gnt_idx_r;
    assign preempt = preempt_r;
    assign busy    = busy_r;

endmodule
